// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the loop.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             div_zero
);

  localparam logic [6:0]       OPCODE_OP = 7'b0110011;
  localparam logic [6:0]       FUNCT7_M  = 7'b0000001;
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               signed_q, signed_d;
  logic               rem_sel_q, rem_sel_d;
  logic               dvd_neg_q, dvd_neg_d;
  logic               dsr_neg_q, dsr_neg_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               div_zero_q, div_zero_d;

  // Decode and operand conditioning for the accept cycle
  logic               accept;
  logic               in_signed;
  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   op1_abs, op2_abs;
  logic               overflow;

  assign accept    = in_valid && (state_q == S_IDLE) && (opcode == OPCODE_OP)
                     && (funct7 == FUNCT7_M) && funct3[2];
  assign in_signed = ~funct3[0];
  assign op1_neg   = in_signed & op1[WIDTH-1];
  assign op2_neg   = in_signed & op2[WIDTH-1];
  assign op1_abs   = op1_neg ? -op1 : op1;
  assign op2_abs   = op2_neg ? -op2 : op2;
  assign overflow  = in_signed && (op1 == MOST_NEG) && (op2 == '1);

  // One restoring step: the trial difference is one bit wider so its sign bit
  // tells whether the shifted partial remainder reached the divisor.
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     trial;
  logic               step_ok;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dsr_q};
  assign step_ok   = ~trial[WIDTH];
  assign rem_next  = step_ok ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_next  = {quo_q[WIDTH-2:0], step_ok};
  assign quo_fix   = (signed_q && (dvd_neg_q ^ dsr_neg_q)) ? -quo_next : quo_next;
  assign rem_fix   = (signed_q && dvd_neg_q) ? -rem_next : rem_next;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dsr_d      = dsr_q;
    cnt_d      = cnt_q;
    signed_d   = signed_q;
    rem_sel_d  = rem_sel_q;
    dvd_neg_d  = dvd_neg_q;
    dsr_neg_d  = dsr_neg_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            signed_d   = in_signed;
            rem_sel_d  = funct3[1];
            dvd_neg_d  = op1_neg;
            dsr_neg_d  = op2_neg;
            dsr_d      = op2_abs;
            quo_d      = op1_abs;
            rem_d      = '0;
            cnt_d      = '0;
            div_zero_d = 1'b0;
            if (op2 == '0) begin
              result_d   = funct3[1] ? op1 : '1;
              div_zero_d = 1'b1;
              state_d    = S_DONE;
            end else if (overflow) begin
              result_d = funct3[1] ? '0 : op1;
              state_d  = S_DONE;
            end else begin
              state_d = S_DIVIDE;
            end
          end
        end
        S_DIVIDE: begin
          rem_d = rem_next;
          quo_d = quo_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            result_d = rem_sel_q ? rem_fix : quo_fix;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      dsr_q      <= '0;
      cnt_q      <= '0;
      signed_q   <= 1'b0;
      rem_sel_q  <= 1'b0;
      dvd_neg_q  <= 1'b0;
      dsr_neg_q  <= 1'b0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dsr_q      <= dsr_d;
      cnt_q      <= cnt_d;
      signed_q   <= signed_d;
      rem_sel_q  <= rem_sel_d;
      dvd_neg_q  <= dvd_neg_d;
      dsr_neg_q  <= dsr_neg_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: quotient/remainder values, latency,
// special cases, output hold, flush and mid-operation reset.
module tb_div_unit;

  localparam logic [6:0] OPCODE_OP = 7'b0110011;
  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;
  logic        div_zero;

  int passed = 0;
  int total  = 0;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Present an instruction for one accept edge; lat counts edges from the
  // accept edge (inclusive) until out_valid is seen, capped at 100.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = OPCODE_OP;
    funct7   = 7'b0000001;
    funct3   = f3;
    op1      = a;
    op2      = b;
    @(posedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_res, input logic exp_dz,
                     input int exp_lat);
    int lat;
    issue(f3, a, b, lat);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_div_zero"}, 32'(div_zero), 32'(exp_dz));
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clk);
    #1;
    check({tag, "_ready_after"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  task automatic watch(input int n, output logic seen);
    seen = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
  endtask

  initial begin
    logic seen;
    logic stable;
    int   lat;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op1       = '0;
    op2       = '0;
    opcode    = '0;
    funct3    = '0;
    funct7    = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_flags", {29'd0, out_valid, busy, div_zero}, 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;

    run("div_100_7",   F_DIV,  32'd100,      32'd7,        32'h0000000E, 1'b0, 33);
    run("rem_100_7",   F_REM,  32'd100,      32'd7,        32'h00000002, 1'b0, 33);
    run("div_m20_3",   F_DIV,  32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 1'b0, 33);
    run("rem_m20_3",   F_REM,  32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 1'b0, 33);
    run("remu_big_3",  F_REMU, 32'hFFFFFFEC, 32'd3,        32'h00000002, 1'b0, 33);
    run("div_7_m2",    F_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33);
    run("rem_7_m2",    F_REM,  32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
    run("divu_zero",   F_DIVU, 32'h1234,     32'd0,        32'hFFFFFFFF, 1'b1, 1);
    run("rem_zero",    F_REM,  32'h1234,     32'd0,        32'h00001234, 1'b1, 1);
    run("div_ovf",     F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
    run("rem_ovf",     F_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1);
    run("divu_mneg",   F_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33);
    run("remu_mneg",   F_REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33);

    // Output held while downstream stalls
    out_ready = 1'b0;
    issue(F_DIV, 32'd100, 32'd7, lat);
    check("hold_latency", 32'(lat), 32'd33);
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || result !== 32'h0000000E || div_zero) stable = 1'b0;
    end
    check("hold_stable", 32'(stable), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release", {30'd0, in_ready, out_valid}, 32'b10);
    run("divu_9_2", F_DIVU, 32'd9, 32'd2, 32'h00000004, 1'b0, 33);

    // Flush during DIVIDE
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = OPCODE_OP;
    funct7   = 7'b0000001;
    funct3   = F_DIV;
    op1      = 32'd1000;
    op2      = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("inflight_busy", {30'd0, busy, in_ready}, 32'b10);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_idle", {30'd0, in_ready, out_valid}, 32'b10);
    watch(40, seen);
    check("flush_no_valid", 32'(seen), 32'd0);
    run("div_50_5_a", F_DIV, 32'd50, 32'd5, 32'h0000000A, 1'b0, 33);

    // Asynchronous reset during DIVIDE
    @(negedge clk);
    in_valid = 1'b1;
    funct3   = F_DIV;
    op1      = 32'd1000;
    op2      = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_state", {29'd0, in_ready, out_valid, busy}, 32'b100);
    check("rst_mid_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch(40, seen);
    check("rst_no_valid", 32'(seen), 32'd0);
    run("div_50_5_b", F_DIV, 32'd50, 32'd5, 32'h0000000A, 1'b0, 33);

    // Non-M OP instruction is never accepted
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = OPCODE_OP;
    funct7   = 7'b0000000;
    funct3   = F_DIV;
    op1      = 32'd100;
    op2      = 32'd7;
    stable   = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (!in_ready || busy) stable = 1'b0;
    end
    check("nonm_ignored", 32'(stable), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    watch(40, seen);
    check("nonm_no_valid", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 divide/remainder unit for the RV32M DIV, DIVU, REM and REMU instructions.
- Sits in the execute stage beside the combinational alu and takes the same decoded operand bus: op1, op2, opcode, funct3, funct7.
- Its result is muxed with the alu result ahead of the EX/MEM register. The core stalls via in_ready/out_valid while a divide is in flight.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  decode presents a valid instruction on the operand bus
- in_ready  output  1  unit can accept; high only in IDLE
- op1  input  WIDTH  dividend (rs1)
- op2  input  WIDTH  divisor (rs2)
- opcode  input  7  instruction opcode
- funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- funct7  input  7  must be 0000001 (M extension)
- flush  input  1  pipeline kill; aborts any operation in flight
- out_valid  output  1  result is valid
- out_ready  input  1  downstream consumes result
- result  output  WIDTH  quotient or remainder
- busy  output  1  high in DIVIDE or DONE
- div_zero  output  1  qualifies result: divisor was zero; valid with out_valid

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. in_ready=1, out_valid=0, busy=0, result=0, div_zero=0. Counter and internal registers are cleared.
- Accept: in_valid & in_ready & opcode==OP & funct7==0000001 & funct3[2]==1, sampled on a clk edge.
  - Any other in_valid while in IDLE is ignored: no state change, in_ready stays 1.
- On accept, latch the following:
  - signed = !funct3[0]; rem_sel = funct3[1].
  - Sign of dividend and divisor.
  - Absolute values when signed, raw values otherwise.
- States:
  - IDLE:
    - Accept with op2==0 -> DONE: result = rem_sel ? op1 : all-ones, div_zero=1.
    - Accept, signed, op1==most-negative, op2==all-ones -> DONE: result = rem_sel ? 0 : op1 (overflow).
    - Any other accept -> DIVIDE with counter=0.
  - DIVIDE: one restoring step per cycle.
    - Shift {rem,quo} left by 1, then trial subtract the divisor from rem.
    - If the difference is non-negative, keep it and set the quotient LSB.
    - Counter increments each cycle. After step WIDTH-1 -> DONE.
  - DONE:
    - Sign correction is applied when the result is registered on entry to DONE.
    - Signed quotient is negated iff the input signs differ.
    - Signed remainder takes the sign of the dividend.
    - out_valid=1. result and div_zero are held stable until consumed.
    - out_ready -> IDLE. out_valid drops the next cycle and in_ready rises the same cycle.
- Latency:
  - Normal: out_valid rises WIDTH+1 edges after the accept edge, i.e. 33 for WIDTH=32.
  - Special cases: out_valid rises 1 edge after accept.
- Back-to-back: the unit cannot accept in the cycle out_valid&out_ready is high. The earliest next accept is the following edge, so minimum issue spacing is latency+1.
- flush:
  - Takes effect synchronously in any state -> IDLE. out_valid=0 the next cycle and any partial or held result is discarded.
  - flush has priority over accept and over out_ready.
- result/div_zero are registered outputs and never change while out_valid=1.
- A mid-operation async reset behaves identically to power-up reset; no residual out_valid.
- Arithmetic:
  - Internal remainder is WIDTH+1 bits so the trial subtract does not overflow.
  - Negation is two's complement mod 2^WIDTH.
  - DIVU/REMU never apply sign correction; op1=most-negative is treated as 2^(WIDTH-1) unsigned.

Test Plan:
- DIV 100/7 (signed), out_ready=1 -> out_valid exactly 33 cycles after accept, result=0x0000000E, div_zero=0. Repeat with REM -> 0x00000002.
- DIV -20/3 -> 0xFFFFFFFA. REM -20/3 -> 0xFFFFFFFE. REMU 0xFFFFFFEC/3 -> 0x00000002.
- DIVU 0x1234/0 -> result=0xFFFFFFFF, div_zero=1, out_valid 1 cycle after accept. REM 0x1234/0 -> 0x00001234.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 after 1 cycle. REM of the same operands -> 0x00000000.
- Hold out_ready=0 for 5 cycles after out_valid -> result and out_valid stable, in_ready=0. Raise out_ready -> in_ready=1 the next cycle. A second DIVU 9/2 issued then returns 0x00000004.
- Assert flush at cycle 10 of a DIV. Separately, pulse rst_n low mid-DIVIDE. Each case -> in_ready=1 the next cycle, no out_valid. A fresh DIV 50/5 then returns 0x0000000A. A non-M OP instruction (funct7=0) with in_valid -> never accepted.
